// File: rtl/scpad_rd_arbiter_if.sv
// Scratchpad read-path arbiter bus: requester side, bank/xbar side,
// crossbar return path and flush/drain control.
interface scpad_rd_arbiter_if #(
  parameter int NUM_REQ      = 3,
  parameter int SRC_W        = 3,
  parameter int ROW_W        = 8,
  parameter int NUM_COLS     = 32,
  parameter int MAX_INFLIGHT = 4
);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ROW_W-1:0]    req_row;
  logic [NUM_REQ*NUM_COLS-1:0] req_mask;
  logic                        wr_busy;
  logic                        flush_req;
  logic                        flush_done;
  logic                        spad_req_valid;
  logic [ROW_W-1:0]            spad_req_row;
  logic [SRC_W-1:0]            spad_req_src;
  logic [NUM_COLS-1:0]         spad_req_mask;
  logic                        res_valid;
  logic [SRC_W-1:0]            res_src;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [NUM_REQ-1:0]          rsp_ready;
  logic                        r_stall;
  logic [INF_W-1:0]            inflight;
  logic                        busy;

  modport slave (
    input  req_valid, req_row, req_mask,
    input  wr_busy, flush_req,
    input  res_valid, res_src, rsp_ready,
    output req_ready, flush_done,
    output spad_req_valid, spad_req_row,
    output spad_req_src, spad_req_mask,
    output rsp_valid, r_stall, inflight, busy
  );

  modport master (
    output req_valid, req_row, req_mask,
    output wr_busy, flush_req,
    output res_valid, res_src, rsp_ready,
    input  req_ready, flush_done,
    input  spad_req_valid, spad_req_row,
    input  spad_req_src, spad_req_mask,
    input  rsp_valid, r_stall, inflight, busy
  );
endinterface

// File: rtl/scpad_rd_arbiter.sv
// Round-robin read-port arbiter for one scratchpad: grants, tags by src,
// tracks in-flight reads, routes returns and handles flush/drain.
module scpad_rd_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int SRC_W        = 3,
  parameter int ROW_W        = 8,
  parameter int NUM_COLS     = 32,
  parameter int XBAR_LATENCY = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input logic              clk,
  input logic              n_rst,
  scpad_rd_arbiter_if.slave bus
);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    rr_q, rr_d;
  logic [INF_W-1:0]    inf_q, inf_d;
  logic                sv_q, sv_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [NUM_COLS-1:0] mask_q, mask_d;

  logic                src_ok, rdy_sel, stall, cmpl;
  logic                can_issue, accept;
  logic                hi_vld, lo_vld, gnt_vld;
  logic [SRC_W-1:0]    hi_gnt, lo_gnt, gnt;
  logic [ROW_W-1:0]    row_sel;
  logic [NUM_COLS-1:0] mask_sel;

  // Route the crossbar return by tag; unknown tags never stall or complete
  always_comb begin
    src_ok        = 1'b0;
    rdy_sel       = 1'b0;
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.res_src == SRC_W'(i)) begin
        src_ok           = 1'b1;
        rdy_sel          = bus.rsp_ready[i];
        bus.rsp_valid[i] = bus.res_valid;
      end
    end
    stall = bus.res_valid && src_ok && !rdy_sel;
    cmpl  = bus.res_valid && src_ok && rdy_sel;
  end

  // Rotating-priority pick: lowest index at/above rr pointer, else wrap
  always_comb begin
    hi_vld = 1'b0;
    hi_gnt = '0;
    lo_vld = 1'b0;
    lo_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && SRC_W'(i) >= rr_q) begin
        hi_vld = 1'b1;
        hi_gnt = SRC_W'(i);
      end
      if (bus.req_valid[i]) begin
        lo_vld = 1'b1;
        lo_gnt = SRC_W'(i);
      end
    end
    gnt_vld = hi_vld || lo_vld;
    gnt     = hi_vld ? hi_gnt : lo_gnt;
  end

  // Issue qualification, ready fan-out and payload mux for the winner
  always_comb begin
    can_issue = (state_q == RUN) && !bus.wr_busy && !stall &&
                (inf_q < INF_W'(MAX_INFLIGHT));
    accept    = can_issue && gnt_vld;
    row_sel   = '0;
    mask_sel  = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == SRC_W'(i)) begin
        row_sel  = bus.req_row[i*ROW_W +: ROW_W];
        mask_sel = bus.req_mask[i*NUM_COLS +: NUM_COLS];
        bus.req_ready[i] = accept;
      end
    end
  end

  // Next values for issue register, rr pointer and in-flight counter
  always_comb begin
    sv_d   = sv_q;
    row_d  = row_q;
    src_d  = src_q;
    mask_d = mask_q;
    rr_d   = rr_q;
    inf_d  = inf_q;
    if (!stall) begin
      sv_d = accept;
      if (accept) begin
        row_d  = row_sel;
        src_d  = gnt;
        mask_d = mask_sel;
      end
    end
    if (accept) begin
      rr_d = (gnt == SRC_W'(NUM_REQ - 1)) ? '0 : gnt + SRC_W'(1);
    end
    unique case ({accept, cmpl})
      2'b10:   inf_d = inf_q + INF_W'(1);
      2'b01:   inf_d = (inf_q == '0) ? '0 : inf_q - INF_W'(1);
      default: inf_d = inf_q;
    endcase
  end

  // Flush sequencing: stop granting, wait for empty path, pulse done
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!bus.flush_req) state_d = RUN;
      RUN:   if (bus.flush_req) state_d = DRAIN;
      DRAIN: if (inf_q == '0 && !sv_q) state_d = DONE;
      DONE:  state_d = bus.flush_req ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      inf_q   <= '0;
      sv_q    <= 1'b0;
      row_q   <= '0;
      src_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      inf_q   <= inf_d;
      sv_q    <= sv_d;
      row_q   <= row_d;
      src_q   <= src_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.spad_req_valid = sv_q;
  assign bus.spad_req_row   = row_q;
  assign bus.spad_req_src   = src_q;
  assign bus.spad_req_mask  = mask_q;
  assign bus.r_stall        = stall;
  assign bus.flush_done     = (state_q == DONE);
  assign bus.inflight       = inf_q;
  assign bus.busy           = (inf_q != '0) || sv_q;

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!n_rst) !(cmpl && inf_q == '0)
  );
endmodule

// File: tb/tb_scpad_rd_arbiter.sv
// Directed vector bench for scpad_rd_arbiter: per-cycle stimulus with
// expected handshake, routing, counter and flush values.
module tb_scpad_rd_arbiter;
  localparam int NUM_REQ  = 3;
  localparam int SRC_W    = 3;
  localparam int ROW_W    = 8;
  localparam int NUM_COLS = 32;
  localparam int XBAR_LAT = 2;
  localparam int MAX_INF  = 4;

  typedef struct {
    logic       pre;
    logic [2:0] rv;
    logic [2:0] rdy;
    logic       resv;
    logic [2:0] ress;
    logic       wb;
    logic       fl;
    logic [2:0] e_rdy;
    logic [2:0] e_rsp;
    logic       e_stl;
    logic       e_sv;
    logic [2:0] e_src;
    logic [2:0] e_inf;
    logic       e_fd;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tv[$];
  logic [ROW_W-1:0]    rows[NUM_REQ];
  logic [NUM_COLS-1:0] masks[NUM_REQ];

  always #5 clk = ~clk;

  scpad_rd_arbiter_if #(
    .NUM_REQ(NUM_REQ), .SRC_W(SRC_W), .ROW_W(ROW_W),
    .NUM_COLS(NUM_COLS), .MAX_INFLIGHT(MAX_INF)
  ) bus ();

  scpad_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .SRC_W(SRC_W), .ROW_W(ROW_W),
    .NUM_COLS(NUM_COLS), .XBAR_LATENCY(XBAR_LAT),
    .MAX_INFLIGHT(MAX_INF)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  function automatic vec_t mk(
    input logic pre, input logic [2:0] rv, input logic [2:0] rdy,
    input logic resv, input logic [2:0] ress, input logic wb,
    input logic fl, input logic [2:0] e_rdy, input logic [2:0] e_rsp,
    input logic e_stl, input logic e_sv, input logic [2:0] e_src,
    input logic [2:0] e_inf, input logic e_fd);
    vec_t v;
    v.pre = pre; v.rv = rv; v.rdy = rdy; v.resv = resv;
    v.ress = ress; v.wb = wb; v.fl = fl; v.e_rdy = e_rdy;
    v.e_rsp = e_rsp; v.e_stl = e_stl; v.e_sv = e_sv;
    v.e_src = e_src; v.e_inf = e_inf; v.e_fd = e_fd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h, expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_sv", idx, 32'(bus.spad_req_valid), 32'd0);
    chk("rst_row", idx, 32'(bus.spad_req_row), 32'd0);
    chk("rst_src", idx, 32'(bus.spad_req_src), 32'd0);
    chk("rst_mask", idx, 32'(bus.spad_req_mask), 32'd0);
    chk("rst_inf", idx, 32'(bus.inflight), 32'd0);
    chk("rst_fd", idx, 32'(bus.flush_done), 32'd0);
    chk("rst_busy", idx, 32'(bus.busy), 32'd0);
    chk("rst_rdy", idx, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    n_rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.res_valid = 1'b0;
    bus.res_src = '0;
    bus.wr_busy = 1'b0;
    bus.flush_req = 1'b0;
    #1;
    chk_reset(idx);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    rows[0] = 8'h20; rows[1] = 8'h12; rows[2] = 8'h33;
    masks[0] = 32'h0000_00FF;
    masks[1] = 32'hFFFF_FFFF;
    masks[2] = 32'hA5A5_A5A5;
    bus.req_row  = {rows[2], rows[1], rows[0]};
    bus.req_mask = {masks[2], masks[1], masks[0]};
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.res_valid = 1'b0;
    bus.res_src = '0;
    bus.wr_busy = 1'b0;
    bus.flush_req = 1'b0;

    // single requester 1, then an out-of-range tag
    tv.push_back(mk(1,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,1,1,1,0));
    tv.push_back(mk(0,3'b000,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,1,0));
    tv.push_back(mk(0,3'b000,3'b000,1,5,0,0, 3'b000,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,0,0));
    // all valid for 9 accepts, returns two cycles after issue
    tv.push_back(mk(1,3'b111,3'b111,0,0,0,0, 3'b001,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b010,3'b000,0,1,0,1,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b100,3'b000,0,1,1,2,0));
    tv.push_back(mk(0,3'b111,3'b111,1,0,0,0, 3'b001,3'b001,0,1,2,3,0));
    tv.push_back(mk(0,3'b111,3'b111,1,1,0,0, 3'b010,3'b010,0,1,0,3,0));
    tv.push_back(mk(0,3'b111,3'b111,1,2,0,0, 3'b100,3'b100,0,1,1,3,0));
    tv.push_back(mk(0,3'b111,3'b111,1,0,0,0, 3'b001,3'b001,0,1,2,3,0));
    tv.push_back(mk(0,3'b111,3'b111,1,1,0,0, 3'b010,3'b010,0,1,0,3,0));
    tv.push_back(mk(0,3'b111,3'b111,1,2,0,0, 3'b100,3'b100,0,1,1,3,0));
    tv.push_back(mk(0,3'b000,3'b111,1,0,0,0, 3'b000,3'b001,0,1,2,3,0));
    tv.push_back(mk(0,3'b000,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,2,0));
    tv.push_back(mk(0,3'b000,3'b111,1,2,0,0, 3'b000,3'b100,0,0,0,1,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,0,0));
    // requester 2 not ready for 4 cycles
    tv.push_back(mk(0,3'b100,3'b111,0,0,0,0, 3'b100,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b001,3'b111,0,0,0,0, 3'b001,3'b000,0,1,2,1,0));
    tv.push_back(mk(0,3'b100,3'b011,1,2,0,0, 3'b000,3'b100,1,1,0,2,0));
    tv.push_back(mk(0,3'b100,3'b011,1,2,0,0, 3'b000,3'b100,1,1,0,2,0));
    tv.push_back(mk(0,3'b100,3'b011,1,2,0,0, 3'b000,3'b100,1,1,0,2,0));
    tv.push_back(mk(0,3'b100,3'b011,1,2,0,0, 3'b000,3'b100,1,1,0,2,0));
    tv.push_back(mk(0,3'b100,3'b111,1,2,0,0, 3'b100,3'b100,0,1,0,2,0));
    tv.push_back(mk(0,3'b000,3'b111,1,0,0,0, 3'b000,3'b001,0,1,2,2,0));
    tv.push_back(mk(0,3'b000,3'b111,1,2,0,0, 3'b000,3'b100,0,0,0,1,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,0,0));
    // no returns: fill to MAX_INFLIGHT, one completion, one grant
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,1,1,1,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,1,1,2,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,1,1,3,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b000,3'b000,0,1,1,4,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,4,0));
    tv.push_back(mk(0,3'b010,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,4,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,0,0,3,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b000,3'b000,0,1,1,4,0));
    tv.push_back(mk(0,3'b000,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,4,0));
    tv.push_back(mk(0,3'b000,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,3,0));
    tv.push_back(mk(0,3'b000,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,2,0));
    tv.push_back(mk(0,3'b000,3'b111,1,1,0,0, 3'b000,3'b010,0,0,0,1,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,0,0));
    // flush with two reads in flight
    tv.push_back(mk(0,3'b001,3'b111,0,0,0,0, 3'b001,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b010,3'b111,0,0,0,0, 3'b010,3'b000,0,1,0,1,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,1, 3'b000,3'b000,0,1,1,2,0));
    tv.push_back(mk(0,3'b111,3'b111,1,0,0,1, 3'b000,3'b001,0,0,0,2,0));
    tv.push_back(mk(0,3'b111,3'b111,1,1,0,1, 3'b000,3'b010,0,0,0,1,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,1, 3'b000,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,1, 3'b000,3'b000,0,0,0,0,1));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,1, 3'b000,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b100,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,1,2,1,0));
    tv.push_back(mk(0,3'b000,3'b111,1,2,0,0, 3'b000,3'b100,0,0,0,1,0));
    tv.push_back(mk(0,3'b000,3'b111,0,0,0,0, 3'b000,3'b000,0,0,0,0,0));
    // wr_busy for 5 cycles mid-stream
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b001,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b010,3'b000,0,1,0,1,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,1,0, 3'b000,3'b000,0,1,1,2,0));
    tv.push_back(mk(0,3'b111,3'b111,1,0,1,0, 3'b000,3'b001,0,0,0,2,0));
    tv.push_back(mk(0,3'b111,3'b111,1,1,1,0, 3'b000,3'b010,0,0,0,1,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,1,0, 3'b000,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,1,0, 3'b000,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b100,3'b000,0,0,0,0,0));
    tv.push_back(mk(0,3'b111,3'b111,0,0,0,0, 3'b001,3'b000,0,1,2,1,0));

    foreach (tv[k]) begin
      if (tv[k].pre) do_reset(k);
      @(negedge clk);
      bus.req_valid = tv[k].rv;
      bus.rsp_ready = tv[k].rdy;
      bus.res_valid = tv[k].resv;
      bus.res_src   = tv[k].ress;
      bus.wr_busy   = tv[k].wb;
      bus.flush_req = tv[k].fl;
      #1;
      chk("req_ready", k, 32'(bus.req_ready), 32'(tv[k].e_rdy));
      chk("rsp_valid", k, 32'(bus.rsp_valid), 32'(tv[k].e_rsp));
      chk("r_stall", k, 32'(bus.r_stall), 32'(tv[k].e_stl));
      chk("spad_valid", k, 32'(bus.spad_req_valid), 32'(tv[k].e_sv));
      chk("inflight", k, 32'(bus.inflight), 32'(tv[k].e_inf));
      chk("flush_done", k, 32'(bus.flush_done), 32'(tv[k].e_fd));
      chk("busy", k, 32'(bus.busy),
          32'((tv[k].e_inf != 3'd0) || tv[k].e_sv));
      if (tv[k].e_sv) begin
        chk("spad_src", k, 32'(bus.spad_req_src), 32'(tv[k].e_src));
        chk("spad_row", k, 32'(bus.spad_req_row),
            32'(rows[tv[k].e_src]));
        chk("spad_mask", k, 32'(bus.spad_req_mask),
            32'(masks[tv[k].e_src]));
      end
    end

    // asynchronous reset mid-stream, away from any clock edge
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset(tv.size());
    @(negedge clk);
    bus.req_valid = '0;
    n_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
